fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage: owns the PC, drives the instruction-memory read handshake and
//  buffers fetched words in a small FIFO. Produces fetch_imemload/fetch_pc_4 for the
//  fetch/decode pipeline register, which latches on EN. Handles branch/jump redirects,
//  including squashing an in-flight memory read, and stops fetching on halt.
// PARAMETERS
//  PC_INIT    32'h0000_0000  PC value loaded on reset
//  BUF_DEPTH  2              instruction buffer entries (power of 2, >=2)
// PORTS
//  CLK             in   1   clock; all state updates on rising edge
//  RST             in   1   synchronous, active-high reset
//  imemREN         out  1   instruction read request
//  imemaddr        out  32  read address (word aligned)
//  ihit            in   1   memory returns imemload for imemaddr this cycle
//  imemload        in   32  instruction word, valid when ihit
//  redirect        in   1   branch/jump taken; restart fetch at redirect_pc
//  redirect_pc     in   32  new PC; bits [1:0] ignored (forced 0)
//  halt            in   1   HALT decoded; stop fetching until reset
//  EN              in   1   fetch/decode register enable; pops buffer head when valid
//  fetch_imemload  out  32  buffer head instruction; 32'h0 when empty
//  fetch_pc_4      out  32  buffer head PC+4; 32'h0 when empty
//  fetch_valid     out  1   buffer non-empty
// BEHAVIOUR
//  Reset: pc=PC_INIT, count=0, rd/wr ptr=0, state=RUN. fetch_valid=0, fetch_* = 0.
//   imemREN=1, imemaddr=PC_INIT from the first post-reset cycle. Reset mid-read
//   abandons it; no word is pushed.
//  States: RUN, SQUASH, HALTED.
//  imemREN = (RUN && count<BUF_DEPTH) || SQUASH; imemaddr = pc (RUN) or sq_addr (SQUASH).
//  RUN:
//   - ihit && !redirect: push {imemload, pc+4}; pc<=pc+4 (mod 2^32). Entry visible
//     on outputs the following cycle (1-cycle latency ihit -> fetch_valid).
//   - redirect: buffer flushed (count=0), pc<=redirect_pc&~3. If imemREN=1 and ihit=0,
//     sq_addr<=pc, go SQUASH. If ihit=1 same cycle, word discarded, stay RUN.
//   - halt (no redirect): flush buffer, go HALTED; pending read squashed like redirect.
//   - count==BUF_DEPTH: imemREN deasserts; resumes the cycle after a pop.
//  SQUASH: imemREN held at sq_addr until ihit; returned word discarded, -> RUN next cycle.
//   redirect in SQUASH: pc<=redirect_pc&~3, buffer flushed, stay SQUASH.
//   halt in SQUASH: complete squash, then HALTED.
//  HALTED: imemREN=0, buffer empty, fetch_valid=0; only RST exits.
//  Buffer: pop when EN && fetch_valid. Push and pop same cycle: count unchanged; push
//   accepted even when full only if pop occurs that cycle. Pointers wrap modulo
//   BUF_DEPTH. Redirect/halt beat push and pop (flush wins).
//  Priority: RST > redirect > halt > ihit/EN.
// TESTING
//  1 Reset, ihit every cycle, EN=1 -> imemaddr 0,4,8..; fetch_pc_4 4,8,12.. one cycle behind.
//  2 EN=0, ihit=1 -> 2 pushes (pc_4 4,8) then imemREN=0 at imemaddr 8; EN=1 one cycle
//    -> pops pc_4=4, imemREN=1 next cycle.
//  3 ihit=0 at addr 0x10, redirect=1 redirect_pc=0x103 -> SQUASH holds addr 0x10; ihit
//    word dropped; next request addr 0x100, fetch_valid=0 until it returns.
//  4 redirect & ihit same cycle at addr 0x20 -> word dropped, next imemaddr=redirect_pc,
//    no SQUASH cycle, buffer empty.
//  5 halt with 2 buffered entries -> fetch_valid=0 next cycle, imemREN=0 forever until RST.
//  6 RST asserted during pending read at 0x40 -> next cycle imemaddr=PC_INIT, count=0.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Owns the PC, drives the
//                instruction-memory read handshake and buffers fetched words
//                in a small FIFO feeding the fetch/decode pipeline register.
//                Handles branch/jump redirects (including squashing a read
//                that is already in flight) and stops fetching on halt.
//  Ports       : CLK, RST            clock / synchronous active-high reset
//                imemREN, imemaddr   read request and word-aligned address
//                ihit, imemload      memory response and returned word
//                redirect, redirect_pc  taken branch/jump and its target
//                halt                HALT decoded, stop fetching until reset
//                EN                  fetch/decode enable, pops buffer head
//                fetch_imemload, fetch_pc_4, fetch_valid  buffer head view
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        EN,
  output logic [31:0] fetch_imemload,
  output logic [31:0] fetch_pc_4,
  output logic        fetch_valid
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     sq_addr_q, sq_addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            halt_pend_q, halt_pend_d;

  logic [31:0]     buf_instr_q [BUF_DEPTH];
  logic [31:0]     buf_pc4_q   [BUF_DEPTH];

  logic            push;
  logic            pop;

  // Request/address depend on state only, so the memory sees a stable request.
  always_comb begin
    imemREN  = ((state_q == RUN) && (count_q < C_DEPTH)) || (state_q == SQUASH);
    imemaddr = (state_q == SQUASH) ? sq_addr_q : pc_q;
  end

  assign fetch_valid    = (count_q != '0);
  assign fetch_imemload = fetch_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
  assign fetch_pc_4     = fetch_valid ? buf_pc4_q[rd_ptr_q]   : 32'h0;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sq_addr_d   = sq_addr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    halt_pend_d = halt_pend_q;
    push        = 1'b0;
    pop         = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect) begin
          count_d  = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          pc_d     = redirect_pc & ~32'h3;
          // A read that has not returned yet must be drained before the
          // memory can be pointed at the new target.
          if (imemREN && !ihit) begin
            sq_addr_d = pc_q;
            state_d   = SQUASH;
          end
        end else if (halt) begin
          count_d  = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          if (imemREN && !ihit) begin
            sq_addr_d   = pc_q;
            halt_pend_d = 1'b1;
            state_d     = SQUASH;
          end else begin
            state_d = HALTED;
          end
        end else begin
          pop  = EN && fetch_valid;
          // A full buffer only takes a word when the head leaves this cycle.
          push = ihit && ((count_q < C_DEPTH) || pop);
          if (push) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
          count_d = count_q + CW'(push) - CW'(pop);
        end
      end

      SQUASH: begin
        if (redirect) begin
          pc_d     = redirect_pc & ~32'h3;
          count_d  = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end
        // The returned word belongs to the abandoned path and is dropped.
        if (ihit) begin
          state_d = halt_pend_d ? HALTED : RUN;
        end
      end

      HALTED: begin
        count_d  = '0;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      pc_q        <= PC_INIT;
      sq_addr_q   <= PC_INIT;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sq_addr_q   <= sq_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      buf_instr_q[wr_ptr_q] <= imemload;
      buf_pc4_q[wr_ptr_q]   <= pc_q + 32'd4;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        EN;
  logic [31:0] fetch_imemload;
  logic [31:0] fetch_pc_4;
  logic        fetch_valid;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage #(.PC_INIT(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .imemREN        (imemREN),
    .imemaddr       (imemaddr),
    .ihit           (ihit),
    .imemload       (imemload),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .EN             (EN),
    .fetch_imemload (fetch_imemload),
    .fetch_pc_4     (fetch_pc_4),
    .fetch_valid    (fetch_valid)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = 32'h0; redirect = 1'b0;
    redirect_pc = 32'h0; halt = 1'b0; EN = 1'b0;

    // ---- reset state
    tick(); tick();
    chk("rst_valid", {31'h0, fetch_valid}, 32'h0);
    chk("rst_load",  fetch_imemload, 32'h0);
    chk("rst_pc4",   fetch_pc_4, 32'h0);
    chk("rst_ren",   {31'h0, imemREN}, 32'h1);
    chk("rst_addr",  imemaddr, 32'h0);
    RST = 1'b0;

    // ---- 1: streaming fetch, fetch_pc_4 one cycle behind the address
    ihit = 1'b1; EN = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      imemload = 32'hA000_0000 | imemaddr;
      tick();
      chk("s1_addr",  imemaddr, 32'(4 * i));
      chk("s1_valid", {31'h0, fetch_valid}, 32'h1);
      chk("s1_pc4",   fetch_pc_4, 32'(4 * i));
      chk("s1_load",  fetch_imemload, 32'hA000_0000 | 32'(4 * (i - 1)));
    end
    // drain: addr 12, one entry (pc_4 = 12) left
    ihit = 1'b0; EN = 1'b1;
    tick();
    chk("s1_drain_valid", {31'h0, fetch_valid}, 32'h0);
    chk("s1_drain_addr",  imemaddr, 32'hC);

    // ---- 2: fill buffer with EN=0, then one pop resumes requests
    ihit = 1'b1; EN = 1'b0; imemload = 32'hB000_000C;
    tick();
    chk("s2_addr1", imemaddr, 32'h10);
    chk("s2_ren1",  {31'h0, imemREN}, 32'h1);
    imemload = 32'hB000_0010;
    tick();
    chk("s2_addr2", imemaddr, 32'h14);
    chk("s2_ren_full", {31'h0, imemREN}, 32'h0);
    chk("s2_head_pc4", fetch_pc_4, 32'h10);
    ihit = 1'b0;
    tick();
    chk("s2_ren_hold", {31'h0, imemREN}, 32'h0);
    chk("s2_addr_hold", imemaddr, 32'h14);
    EN = 1'b1;
    tick();
    chk("s2_pop_pc4",  fetch_pc_4, 32'h14);
    chk("s2_pop_load", fetch_imemload, 32'hB000_0010);
    chk("s2_ren_back", {31'h0, imemREN}, 32'h1);
    tick();
    chk("s2_empty", {31'h0, fetch_valid}, 32'h0);
    EN = 1'b0;

    // ---- 4: redirect together with ihit -> word dropped, no squash
    ihit = 1'b1; redirect = 1'b1; redirect_pc = 32'h20; imemload = 32'hDEAD_0014;
    tick();
    redirect = 1'b0; ihit = 1'b0;
    chk("s4_addr",  imemaddr, 32'h20);
    chk("s4_valid", {31'h0, fetch_valid}, 32'h0);
    chk("s4_ren",   {31'h0, imemREN}, 32'h1);

    // ---- 3: redirect with read outstanding -> squash holds old address
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    chk("s3_sq_addr", imemaddr, 32'h20);
    chk("s3_sq_ren",  {31'h0, imemREN}, 32'h1);
    tick();
    chk("s3_sq_hold", imemaddr, 32'h20);
    ihit = 1'b1; imemload = 32'hDEAD_0020;
    tick();
    ihit = 1'b0;
    chk("s3_new_addr", imemaddr, 32'h100);
    chk("s3_dropped",  {31'h0, fetch_valid}, 32'h0);
    tick();
    chk("s3_wait_valid", {31'h0, fetch_valid}, 32'h0);
    ihit = 1'b1; imemload = 32'hC000_0100;
    tick();
    ihit = 1'b0;
    chk("s3_ret_valid", {31'h0, fetch_valid}, 32'h1);
    chk("s3_ret_pc4",   fetch_pc_4, 32'h104);
    chk("s3_ret_load",  fetch_imemload, 32'hC000_0100);

    // ---- redirect while squashing updates the target
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    chk("sr_flush", {31'h0, fetch_valid}, 32'h0);
    chk("sr_addr1", imemaddr, 32'h104);
    redirect_pc = 32'h301;
    tick();
    redirect = 1'b0;
    chk("sr_addr2", imemaddr, 32'h104);
    ihit = 1'b1; imemload = 32'hDEAD_0104;
    tick();
    chk("sr_run_addr", imemaddr, 32'h300);
    chk("sr_none",     {31'h0, fetch_valid}, 32'h0);

    // ---- 5: halt with two buffered entries
    imemload = 32'hE000_0300;
    tick();
    imemload = 32'hE000_0304;
    tick();
    chk("s5_full_ren", {31'h0, imemREN}, 32'h0);
    chk("s5_head_pc4", fetch_pc_4, 32'h304);
    ihit = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("s5_valid", {31'h0, fetch_valid}, 32'h0);
    chk("s5_ren",   {31'h0, imemREN}, 32'h0);
    chk("s5_pc4",   fetch_pc_4, 32'h0);
    ihit = 1'b1; EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5_stay_ren",   {31'h0, imemREN}, 32'h0);
      chk("s5_stay_valid", {31'h0, fetch_valid}, 32'h0);
    end
    ihit = 1'b0; EN = 1'b0;

    // ---- 6: reset during a pending read
    RST = 1'b1;
    tick();
    RST = 1'b0;
    ihit = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0; ihit = 1'b0;
    chk("s6_addr40", imemaddr, 32'h40);
    tick();
    RST = 1'b1; ihit = 1'b1; imemload = 32'hDEAD_0040;
    tick();
    RST = 1'b0; ihit = 1'b0;
    chk("s6_addr",  imemaddr, 32'h0);
    chk("s6_valid", {31'h0, fetch_valid}, 32'h0);
    chk("s6_ren",   {31'h0, imemREN}, 32'h1);
    ihit = 1'b1; imemload = 32'hF000_0000;
    tick();
    ihit = 1'b0;
    chk("s6_pc4",  fetch_pc_4, 32'h4);
    chk("s6_load", fetch_imemload, 32'hF000_0000);

    // ---- halt with a read outstanding: squash completes, then halted
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("hs_addr",  imemaddr, 32'h4);
    chk("hs_ren",   {31'h0, imemREN}, 32'h1);
    chk("hs_valid", {31'h0, fetch_valid}, 32'h0);
    ihit = 1'b1;
    tick();
    ihit = 1'b0;
    chk("hs_halted_ren",   {31'h0, imemREN}, 32'h0);
    chk("hs_halted_valid", {31'h0, fetch_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
